// File: rtl/toy_pack.sv
// Shared front-end types: address width and the branch-prediction block
// carried from bpdec to the fetch stage.
package toy_pack;

  localparam int unsigned ADDR_WIDTH   = 32;
  localparam int unsigned OFFSET_WIDTH = 3;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]   pred_pc;
    logic [ADDR_WIDTH-1:0]   tgt_pc;
    logic                    taken;
    logic [OFFSET_WIDTH-1:0] offset;
    logic                    is_cext;
    logic                    carry;
    logic                    need_align;
  } bpu_pkg;

endpackage

// File: rtl/toy_fe_btfifo.sv
// Branch-target FIFO between bpdec and fetch: circular buffer of prediction
// blocks with wrap-bit pointers, flush, almost-full back-pressure and overflow flag.
module toy_fe_btfifo
  import toy_pack::*;
#(
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned AFULL_THRESH = DEPTH - 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     enq_vld,
  output logic                     enq_rdy,
  input  bpu_pkg                   enq_pld,
  output logic                     deq_vld,
  input  logic                     deq_rdy,
  output bpu_pkg                   deq_pld,
  output logic                     afull,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;

  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  bpu_pkg           mem [DEPTH];

  logic full;
  logic empty;
  logic enq_fire;
  logic deq_fire;

  // Status decoded from registered pointers only; no path from deq_rdy.
  always_comb begin
    full    = (wptr[IDX_W-1:0] == rptr[IDX_W-1:0]) && (wptr[IDX_W] != rptr[IDX_W]);
    empty   = (wptr == rptr);
    enq_rdy = ~full;
    deq_vld = ~empty;
    count   = wptr - rptr;
    afull   = (count >= PTR_W'(AFULL_THRESH));
    deq_pld = mem[rptr[IDX_W-1:0]];
  end

  always_comb begin
    enq_fire = enq_vld & enq_rdy & ~flush;
    deq_fire = deq_vld & deq_rdy & ~flush;
  end

  // Pointers wrap naturally modulo 2*DEPTH; flush collapses both to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (enq_fire) wptr <= wptr + PTR_W'(1);
      if (deq_fire) rptr <= rptr + PTR_W'(1);
    end
  end

  // Storage is intentionally left unreset.
  always_ff @(posedge clk) begin
    if (enq_fire) mem[wptr[IDX_W-1:0]] <= enq_pld;
  end

  // Sticky overflow: a push attempted against a full FIFO outside of flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_err <= 1'b0;
    end else if (enq_vld && !enq_rdy && !flush) begin
      ovf_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_toy_fe_btfifo.sv
// Self-checking bench for toy_fe_btfifo: directed scenarios plus random
// traffic compared against a queue-based reference model.
module tb_toy_fe_btfifo;
  import toy_pack::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned AFULL = DEPTH - 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       enq_vld;
  logic       enq_rdy;
  bpu_pkg     enq_pld;
  logic       deq_vld;
  logic       deq_rdy;
  bpu_pkg     deq_pld;
  logic       afull;
  logic [3:0] count;
  logic       ovf_err;

  toy_fe_btfifo #(.DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .enq_vld (enq_vld),
    .enq_rdy (enq_rdy),
    .enq_pld (enq_pld),
    .deq_vld (deq_vld),
    .deq_rdy (deq_rdy),
    .deq_pld (deq_pld),
    .afull   (afull),
    .count   (count),
    .ovf_err (ovf_err)
  );

  always #5 clk = ~clk;

  int     n_chk  = 0;
  int     n_pass = 0;
  bpu_pkg q[$];
  bit     m_ovf;
  int     max_cnt;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic bpu_pkg mk_pld(input logic [31:0] tgt);
    bpu_pkg p;
    p.pred_pc    = $urandom;
    p.tgt_pc     = tgt;
    p.taken      = 1'($urandom);
    p.offset     = 3'($urandom);
    p.is_cext    = 1'($urandom);
    p.carry      = 1'($urandom);
    p.need_align = 1'($urandom);
    return p;
  endfunction

  // Expected outputs follow purely from the model queue occupancy and head.
  task automatic check_outputs(input string ctx);
    int n;
    n = q.size();
    chk({ctx, ".deq_vld"}, 128'(deq_vld), 128'(n != 0));
    chk({ctx, ".enq_rdy"}, 128'(enq_rdy), 128'(n < DEPTH));
    chk({ctx, ".count"},   128'(count),   128'(n));
    chk({ctx, ".afull"},   128'(afull),   128'(n >= AFULL));
    chk({ctx, ".ovf_err"}, 128'(ovf_err), 128'(m_ovf));
    if (n != 0) chk({ctx, ".deq_pld"}, 128'(deq_pld), 128'(q[0]));
  endtask

  // One clock: drive, check pre-edge state, clock, advance the model.
  task automatic step(input string ctx, input bit f, input bit ev, input bit dr, input bpu_pkg p);
    bit can_enq;
    bit can_deq;
    flush   = f;
    enq_vld = ev;
    deq_rdy = dr;
    enq_pld = p;
    #1;
    check_outputs(ctx);
    can_enq = (q.size() < DEPTH);
    can_deq = (q.size() > 0);
    @(posedge clk);
    if (f) begin
      q.delete();
    end else begin
      if (ev && !can_enq) m_ovf = 1'b1;
      if (dr && can_deq) void'(q.pop_front());
      if (ev && can_enq) q.push_back(p);
    end
    if (q.size() > max_cnt) max_cnt = q.size();
    #1;
  endtask

  task automatic idle(input string ctx);
    step(ctx, 1'b0, 1'b0, 1'b0, mk_pld(32'h0));
  endtask

  task automatic fill(input string ctx, input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++)
      step(ctx, 1'b0, 1'b1, 1'b0, mk_pld(base + 32'(i) * 32'h20));
  endtask

  initial begin
    rst_n   = 1'b0;
    flush   = 1'b0;
    enq_vld = 1'b0;
    deq_rdy = 1'b0;
    enq_pld = '0;
    m_ovf   = 1'b0;
    #12;
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Flush colliding with an enqueue at count=5.
    fill("flq_fill", 5, 32'h1000_0000);
    step("flq_flush", 1'b1, 1'b1, 1'b0, mk_pld(32'hdead_0000));
    step("flq_after", 1'b0, 1'b1, 1'b0, mk_pld(32'h1234_5678));
    chk("flq_head", 128'(deq_pld.tgt_pc), 128'(32'h1234_5678));
    step("flq_drain", 1'b0, 1'b0, 1'b1, mk_pld(32'h0));

    // Simultaneous enqueue and dequeue at count=4.
    fill("sim_fill", 4, 32'h2000_0000);
    step("sim_both", 1'b0, 1'b1, 1'b1, mk_pld(32'h2000_0400));
    chk("sim_count", 128'(count), 128'(4));
    chk("sim_head", 128'(deq_pld.tgt_pc), 128'(32'h2000_0020));
    step("sim_flush", 1'b1, 1'b0, 1'b0, mk_pld(32'h0));

    // Streaming order across pointer wrap; occupancy never exceeds one.
    max_cnt = 0;
    for (int i = 0; i < 20; i++)
      step("wrap", 1'b0, 1'b1, 1'b1, mk_pld(32'h3000_0000 + 32'(i)));
    idle("wrap_tail");
    chk("wrap_maxcnt", 128'(max_cnt), 128'(1));

    // Full FIFO with consumer ready: push while full is dropped (and flagged).
    fill("full_fill", 8, 32'h4000_0000);
    step("full_push", 1'b0, 1'b1, 1'b1, mk_pld(32'h4000_9999));
    chk("full_cnt7", 128'(count), 128'(7));
    step("full_accept", 1'b0, 1'b1, 1'b0, mk_pld(32'h4000_aaaa));
    chk("full_cnt8", 128'(count), 128'(8));
    step("full_flush", 1'b1, 1'b0, 1'b0, mk_pld(32'h0));

    // Asynchronous reset mid-stream at count=3.
    fill("rst_fill", 3, 32'h5000_0000);
    flush = 1'b0; enq_vld = 1'b0; deq_rdy = 1'b0;
    rst_n = 1'b0;
    #1;
    q.delete();
    m_ovf = 1'b0;
    check_outputs("rst_mid");
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fill to full with afull/ovf observation.
    fill("fill", 8, 32'h8000_0000);
    chk("fill_cnt", 128'(count), 128'(8));
    chk("fill_rdy", 128'(enq_rdy), 128'(0));
    step("fill_ovf", 1'b0, 1'b1, 1'b0, mk_pld(32'h8000_0100));
    chk("fill_ovf_set", 128'(ovf_err), 128'(1));
    for (int i = 0; i < 8; i++)
      step("fill_drain", 1'b0, 1'b0, 1'b1, mk_pld(32'h0));

    // Randomized traffic, including occasional multi-cycle flushes.
    for (int i = 0; i < 600; i++)
      step("rand", ($urandom_range(0, 15) == 0), 1'($urandom), 1'($urandom),
           mk_pld($urandom));
    idle("final");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
